sum_bcd_seg_driver: RTL and testbench

//  Consumes the (N+1)-bit binary sum from the n-bit adder and shows it in decimal on a

---
 rtl/sum_bcd_seg_driver.sv | 115 +++++++++++
 tb/tb_sum_bcd_seg_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_bcd_seg_driver.sv
// sum_bcd_seg_driver: double-dabble binary-to-BCD with a scanned active-low common-anode 7-segment display
module sum_bcd_seg_driver #(
    parameter int BIN_WIDTH   = 11,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);
    localparam int BW   = 4 * DIGITS;
    localparam int CW   = $clog2(BIN_WIDTH + 1);
    localparam int RW   = $clog2(REFRESH_DIV + 1);
    localparam int IW   = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int MAXV = 10 ** DIGITS - 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t               state, state_nx;
    logic [BIN_WIDTH-1:0] sh;
    logic [BW-1:0]        scr, adj, hi;
    logic [CW-1:0]        cnt;
    logic                 ovf_nx;
    logic [RW-1:0]        rcnt;
    logic [IW-1:0]        idx;
    logic [6:0]           seg_nx;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'b0000001;
            4'd1:    dec = 7'b1001111;
            4'd2:    dec = 7'b0010010;
            4'd3:    dec = 7'b0000110;
            4'd4:    dec = 7'b1001100;
            4'd5:    dec = 7'b0100100;
            4'd6:    dec = 7'b0100000;
            4'd7:    dec = 7'b0001111;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0000100;
            default: dec = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = state == S_IDLE  ? (load ? S_SHIFT : S_IDLE) :
                   state == S_SHIFT ? (cnt == CW'(1) ? S_DONE : S_SHIFT) : S_IDLE;
    end

    assign busy = state != S_IDLE;

    always_comb begin
        adj = scr;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = scr[4*i +: 4] >= 4'd5 ? scr[4*i +: 4] + 4'd3 : scr[4*i +: 4];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sh       <= '0;
            scr      <= '0;
            cnt      <= '0;
            ovf_nx   <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= state == S_DONE;
            if (state == S_IDLE && load) begin
                sh     <= bin_in;
                scr    <= '0;
                cnt    <= CW'(BIN_WIDTH);
                ovf_nx <= 32'(bin_in) > 32'(MAXV);
            end else if (state == S_SHIFT) begin
                {scr, sh} <= {adj[BW-2:0], sh, 1'b0};
                cnt       <= cnt - 1'b1;
            end
            if (state == S_DONE) begin
                bcd_out  <= scr;
                overflow <= ovf_nx;
            end
        end

    // Display reads only the committed result, so a running conversion never shows up mid-way
    always_comb begin
        hi     = bcd_out >> {idx, 2'b00};
        seg_nx = overflow ? 7'b1111110 :
                 (idx != '0 && hi == '0) ? 7'b1111111 : dec(hi[3:0]);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rcnt <= '0;
            idx  <= '0;
            an   <= ~DIGITS'(1);
            seg  <= 7'b0000001;
        end else begin
            rcnt <= rcnt == RW'(REFRESH_DIV - 1) ? '0 : rcnt + 1'b1;
            if (rcnt == RW'(REFRESH_DIV - 1))
                idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
            an  <= ~(DIGITS'(1) << idx);
            seg <= seg_nx;
        end
endmodule

// File: tb/tb_sum_bcd_seg_driver.sv
// tb_sum_bcd_seg_driver: two instances (4 and 3 digits, fast refresh) checked every cycle
// against an arithmetic model, plus directed literal expectations.
module tb_sum_bcd_seg_driver;
    logic       clk = 1'b0;
    logic [1:0] rn  = 2'b00;
    logic [1:0] ld  = 2'b00;
    logic [1:0] dn;
    logic [10:0] bi [2];
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int D = g == 0 ? 4 : 3;
        localparam logic [6:0] SEGS [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        logic           busy_w, done_w, ovf_w;
        logic [4*D-1:0] bcd_w;
        logic [6:0]     seg_w;
        logic [D-1:0]   an_w, ea;
        int             rem, e, pv, i;
        logic [15:0]    mb, pb;
        logic           mo, po, md;

        sum_bcd_seg_driver #(.BIN_WIDTH(11), .DIGITS(D), .REFRESH_DIV(4)) dut (
            .clk(clk), .rst_n(rn[g]), .bin_in(bi[g]), .load(ld[g]), .busy(busy_w),
            .done(done_w), .bcd_out(bcd_w), .overflow(ovf_w), .seg(seg_w), .an(an_w));

        assign dn[g] = done_w;

        function automatic logic [15:0] bcd_of(input int v);
            int r;
            r = v % (10 ** D);
            bcd_of = '0;
            for (int k = 0; k < D; k++) bcd_of[4*k +: 4] = 4'((r / (10 ** k)) % 10);
        endfunction

        function automatic logic [6:0] seg_of(input logic [15:0] b, input logic o, input int p);
            int num;
            num = 0;
            for (int k = D - 1; k >= 0; k--) num = num * 10 + int'(b[4*k +: 4]);
            if (o) return 7'b1111110;
            if (p > 0 && num < 10 ** p) return 7'b1111111;
            return SEGS[(num / (10 ** p)) % 10];
        endfunction

        always @(posedge clk or negedge rn[g])
            if (!rn[g]) begin
                rem <= 0; e <= 0; pv <= 0;
                mb <= '0; pb <= '0; mo <= 1'b0; po <= 1'b0; md <= 1'b0;
            end else begin
                e  <= e + 1;
                pb <= mb;
                po <= mo;
                md <= 1'b0;
                if (rem == 0 && ld[g]) begin
                    rem <= 12;
                    pv  <= int'(bi[g]);
                end else if (rem > 0) begin
                    rem <= rem - 1;
                    if (rem == 1) begin
                        mb <= bcd_of(pv);
                        mo <= pv > 10 ** D - 1;
                        md <= 1'b1;
                    end
                end
            end

        always @(negedge clk) begin
            i  = e == 0 ? 0 : ((e - 1) / 4) % D;
            ea = ~(D'(1) << i);
            check($sformatf("u%0d.busy", g), 32'(busy_w), 32'(rem > 0));
            check($sformatf("u%0d.done", g), 32'(done_w), 32'(md));
            check($sformatf("u%0d.bcd_out", g), 32'(bcd_w), 32'(mb));
            check($sformatf("u%0d.overflow", g), 32'(ovf_w), 32'(mo));
            check($sformatf("u%0d.an", g), 32'(an_w), 32'(ea));
            check($sformatf("u%0d.seg", g), 32'(seg_w), 32'(seg_of(pb, po, i)));
        end
    end

    task automatic run(input int g, input int v);
        int lat;
        @(negedge clk);
        bi[g] = 11'(v);
        ld[g] = 1'b1;
        @(negedge clk);
        ld[g] = 1'b0;
        lat = -1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (dn[g]) begin
                lat = j;
                break;
            end
        end
        check("latency", 32'(lat), 32'd12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] prev;
        logic [3:0] an_exp  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] seg_exp [4] = '{7'b0001111, 7'b1001100, 7'b1001111, 7'b1111111};
        bi[0] = '0;
        bi[1] = '0;
        #12;
        check("rst.busy", 32'(u[0].busy_w), 32'd0);
        check("rst.an", 32'(u[0].an_w), 32'b1110);
        check("rst.seg", 32'(u[0].seg_w), 32'b0000001);
        repeat (2) @(negedge clk);
        #2 rn = 2'b11;

        run(0, 100);
        check("t2.bcd", 32'(u[0].bcd_w), 32'h0100);
        check("t2.ovf", 32'(u[0].ovf_w), 32'd0);
        run(0, 2046);
        check("t3.bcd2046", 32'(u[0].bcd_w), 32'h2046);
        run(0, 0);
        check("t3.bcd0", 32'(u[0].bcd_w), 32'h0000);
        run(0, 147);
        check("t3.bcd147", 32'(u[0].bcd_w), 32'h0147);

        @(negedge clk);
        bi[0] = 11'd99;
        ld[0] = 1'b1;
        @(negedge clk);
        ld[0] = 1'b0;
        n = 0;
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            if (j == 4) begin
                bi[0] = 11'd33;
                ld[0] = 1'b1;
            end
            if (j == 6) ld[0] = 1'b0;
            n += int'(dn[0]);
        end
        check("t4.dones", 32'(n), 32'd1);
        check("t4.bcd", 32'(u[0].bcd_w), 32'h0099);

        run(0, 147);
        prev = u[0].an_w;
        n = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (u[0].an_w == 4'b1110 && prev == 4'b0111) begin
                n = 1;
                break;
            end
            prev = u[0].an_w;
        end
        check("t5.sync", 32'(n), 32'd1);
        for (int p = 0; p < 16; p++) begin
            check("t5.an", 32'(u[0].an_w), 32'(an_exp[p / 4]));
            check("t5.seg", 32'(u[0].seg_w), 32'(seg_exp[p / 4]));
            @(negedge clk);
        end

        run(1, 1000);
        check("t6.ovf", 32'(u[1].ovf_w), 32'd1);
        check("t6.bcd", 32'(u[1].bcd_w), 32'h000);
        repeat (2) @(negedge clk);
        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            check("t6.dash", 32'(u[1].seg_w), 32'b1111110);
        end

        @(negedge clk);
        bi[0] = 11'd555;
        bi[1] = 11'd500;
        ld = 2'b11;
        @(negedge clk);
        ld = 2'b00;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rn = 2'b00;
        #1;
        check("t6.rst.busy", 32'(u[1].busy_w), 32'd0);
        check("t6.rst.done", 32'(u[1].done_w), 32'd0);
        check("t6.rst.bcd", 32'(u[1].bcd_w), 32'd0);
        check("t6.rst.ovf", 32'(u[1].ovf_w), 32'd0);
        check("t1.rst.busy", 32'(u[0].busy_w), 32'd0);
        check("t1.rst.done", 32'(u[0].done_w), 32'd0);
        check("t1.rst.bcd", 32'(u[0].bcd_w), 32'd0);
        check("t1.rst.an", 32'(u[0].an_w), 32'b1110);
        check("t1.rst.seg", 32'(u[0].seg_w), 32'b0000001);
        @(negedge clk);
        #2 rn = 2'b11;
        n = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            n += int'(dn[0]) + int'(dn[1]);
        end
        check("t6.nodone", 32'(n), 32'd0);
        check("t6.bcd_after", 32'(u[1].bcd_w), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
